// File: rtl/conv_pkg.sv
// Shared state encoding, sizing helpers and the saturation range check
// used by the multi-channel convolution engine.
package conv_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_MAC   = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Width of the post-processing datapath: generous enough that bias
   // alignment never overflows for any realistic N/Q/accumulator size.
   localparam int SAT_W = 128;

   function automatic int acc_width(input int n, input int ic, input int k);
      return 2 * n + $clog2(ic * k * k) + 1;
   endfunction

   function automatic int out_side(input int img, input int k, input int stride, input int pad);
      return (img + 2 * pad - k) / stride + 1;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Range check against an n-bit two's complement word:
   // 2'b01 = above the maximum, 2'b10 = below the minimum, 2'b00 = fits.
   function automatic logic [1:0] sat_n(input logic signed [SAT_W-1:0] v, input int n);
      logic signed [SAT_W-1:0] one;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      one    = '0;
      one[0] = 1'b1;
      hi     = (one <<< (n - 1)) - one;
      lo     = -(one <<< (n - 1));
      sat_n  = 2'b00;
      if (v > hi) begin
         sat_n = 2'b01;
      end else if (v < lo) begin
         sat_n = 2'b10;
      end
   endfunction

endpackage

// File: rtl/conv_postproc.sv
// Turns a finished accumulator into an output word: bias alignment,
// arithmetic right shift by Q, saturation to N bits and optional ReLU.
module conv_postproc
   import conv_pkg::*;
#(
   parameter int N     = 16,
   parameter int Q     = 8,
   parameter int ACC_W = 38
) (
   input  logic signed [ACC_W-1:0] acc_i,
   input  logic signed [N-1:0]     bias_i,
   input  logic                    relu_en_i,
   output logic        [N-1:0]     val_o
);

   logic signed [SAT_W-1:0] sum_w;
   logic signed [SAT_W-1:0] shift_w;
   logic        [1:0]       sat_w;

   always_comb begin
      sum_w   = {{(SAT_W-ACC_W){acc_i[ACC_W-1]}}, acc_i}
              + ({{(SAT_W-N){bias_i[N-1]}}, bias_i} <<< Q);
      shift_w = sum_w >>> Q;
      sat_w   = sat_n(shift_w, N);
      val_o   = shift_w[N-1:0];
      if (sat_w[0]) begin
         val_o = {1'b0, {(N-1){1'b1}}};
      end else if (sat_w[1]) begin
         val_o = {1'b1, {(N-1){1'b0}}};
      end
      if (relu_en_i && val_o[N-1]) begin
         val_o = '0;
      end
   end

endmodule

// File: rtl/conv_mc.sv
// Multi-channel 2-D convolution engine: one MAC per cycle over
// f, oy, ox, c, ky, kx, then one WRITE cycle per output pixel.
module conv_mc
   import conv_pkg::*;
#(
   parameter int N            = 16,
   parameter int Q            = 8,
   parameter int IMG_SIZE     = 8,
   parameter int K            = 3,
   parameter int IN_CHANNELS  = 2,
   parameter int OUT_CHANNELS = 4,
   parameter int STRIDE       = 1,
   parameter int PAD          = 0,
   localparam int OUT_SIDE    = out_side(IMG_SIZE, K, STRIDE, PAD),
   localparam int NPIX        = OUT_CHANNELS * OUT_SIDE * OUT_SIDE,
   localparam int IDX_W       = idx_width(NPIX)
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic                                         start,
   input  logic                                         relu_en,
   input  logic [N*IN_CHANNELS*IMG_SIZE*IMG_SIZE-1:0]   feat_mem_flat,
   input  logic [N*OUT_CHANNELS*IN_CHANNELS*K*K-1:0]    weight_mem_flat,
   input  logic [N*OUT_CHANNELS-1:0]                    bias_mem_flat,
   output logic [N*NPIX-1:0]                            out_mem_flat,
   output logic                                         out_valid,
   output logic [IDX_W-1:0]                             out_idx,
   output logic [N-1:0]                                 out_data,
   output logic                                         busy,
   output logic                                         done,
   output logic [1:0]                                   dbg_state_o
);

   localparam int FEAT_WORDS = IN_CHANNELS * IMG_SIZE * IMG_SIZE;
   localparam int W_WORDS    = OUT_CHANNELS * IN_CHANNELS * K * K;
   localparam int ACC_W      = acc_width(N, IN_CHANNELS, K);
   localparam int FI_W       = idx_width(FEAT_WORDS);
   localparam int WI_W       = idx_width(W_WORDS);
   localparam int FW         = idx_width(OUT_CHANNELS);
   localparam int OW         = idx_width(OUT_SIDE);
   localparam int CW         = idx_width(IN_CHANNELS);
   localparam int KW         = idx_width(K);

   logic signed [N-1:0] feat_w   [FEAT_WORDS];
   logic signed [N-1:0] weight_w [W_WORDS];
   logic signed [N-1:0] bias_w   [OUT_CHANNELS];
   logic        [N-1:0] out_words_q [NPIX];

   for (genvar i = 0; i < FEAT_WORDS; i++) begin : g_feat
      assign feat_w[i] = feat_mem_flat[i*N +: N];
   end
   for (genvar i = 0; i < W_WORDS; i++) begin : g_wgt
      assign weight_w[i] = weight_mem_flat[i*N +: N];
   end
   for (genvar i = 0; i < OUT_CHANNELS; i++) begin : g_bias
      assign bias_w[i] = bias_mem_flat[i*N +: N];
   end
   for (genvar i = 0; i < NPIX; i++) begin : g_out
      assign out_mem_flat[i*N +: N] = out_words_q[i];
   end

   logic [1:0]              state_q, state_d;
   logic [FW-1:0]           f_q, f_d;
   logic [OW-1:0]           oy_q, oy_d, ox_q, ox_d;
   logic [CW-1:0]           c_q, c_d;
   logic [KW-1:0]           ky_q, ky_d, kx_q, kx_d;
   logic [IDX_W-1:0]        pix_q, pix_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    relu_q, relu_d;
   logic                    out_valid_q;
   logic [IDX_W-1:0]        out_idx_q;
   logic [N-1:0]            out_data_q;

   int                      ty, tx;
   logic                    tap_ok;
   logic [FI_W-1:0]         fi;
   logic [WI_W-1:0]         wi;
   logic signed [N-1:0]     feat_v;
   logic signed [2*N-1:0]   prod;
   logic [N-1:0]            post_val;
   logic                    wr_en;
   logic                    tap_last, pix_last;

   // Taps outside the map are the zero padding: no array read, product 0.
   always_comb begin
      ty     = int'(oy_q) * STRIDE + int'(ky_q) - PAD;
      tx     = int'(ox_q) * STRIDE + int'(kx_q) - PAD;
      tap_ok = (ty >= 0) && (ty < IMG_SIZE) && (tx >= 0) && (tx < IMG_SIZE);
      fi     = '0;
      if (tap_ok) begin
         fi = FI_W'(int'(c_q) * IMG_SIZE * IMG_SIZE + ty * IMG_SIZE + tx);
      end
      wi     = WI_W'((int'(f_q) * IN_CHANNELS + int'(c_q)) * K * K + int'(ky_q) * K + int'(kx_q));
      feat_v = tap_ok ? feat_w[fi] : '0;
      prod   = feat_v * weight_w[wi];
   end

   assign tap_last = (c_q == CW'(IN_CHANNELS - 1)) && (ky_q == KW'(K - 1)) && (kx_q == KW'(K - 1));
   assign pix_last = (f_q == FW'(OUT_CHANNELS - 1)) && (oy_q == OW'(OUT_SIDE - 1))
                   && (ox_q == OW'(OUT_SIDE - 1));

   conv_postproc #(.N(N), .Q(Q), .ACC_W(ACC_W)) u_post (
      .acc_i     (acc_q),
      .bias_i    (bias_w[f_q]),
      .relu_en_i (relu_q),
      .val_o     (post_val)
   );

   // Control protocol: start is only looked at in IDLE/DONE; done stays high
   // until the next accepted start. Inputs must not change while busy.
   always_comb begin
      state_d = state_q;
      f_d     = f_q;
      oy_d    = oy_q;
      ox_d    = ox_q;
      c_d     = c_q;
      ky_d    = ky_q;
      kx_d    = kx_q;
      pix_d   = pix_q;
      acc_d   = acc_q;
      relu_d  = relu_q;
      wr_en   = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_MAC;
               f_d     = '0;
               oy_d    = '0;
               ox_d    = '0;
               c_d     = '0;
               ky_d    = '0;
               kx_d    = '0;
               pix_d   = '0;
               acc_d   = '0;
               relu_d  = relu_en;
            end
         end
         S_MAC: begin
            acc_d = acc_q + {{(ACC_W-2*N){prod[2*N-1]}}, prod};
            kx_d  = kx_q + 1'b1;
            if (kx_q == KW'(K - 1)) begin
               kx_d = '0;
               ky_d = ky_q + 1'b1;
               if (ky_q == KW'(K - 1)) begin
                  ky_d = '0;
                  c_d  = c_q + 1'b1;
                  if (tap_last) begin
                     c_d     = '0;
                     state_d = S_WRITE;
                  end
               end
            end
         end
         S_WRITE: begin
            wr_en   = 1'b1;
            acc_d   = '0;
            pix_d   = pix_q + 1'b1;
            state_d = S_MAC;
            ox_d    = ox_q + 1'b1;
            if (ox_q == OW'(OUT_SIDE - 1)) begin
               ox_d = '0;
               oy_d = oy_q + 1'b1;
               if (oy_q == OW'(OUT_SIDE - 1)) begin
                  oy_d = '0;
                  f_d  = f_q + 1'b1;
                  if (pix_last) begin
                     f_d     = '0;
                     state_d = S_DONE;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         f_q         <= '0;
         oy_q        <= '0;
         ox_q        <= '0;
         c_q         <= '0;
         ky_q        <= '0;
         kx_q        <= '0;
         pix_q       <= '0;
         acc_q       <= '0;
         relu_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         f_q         <= f_d;
         oy_q        <= oy_d;
         ox_q        <= ox_d;
         c_q         <= c_d;
         ky_q        <= ky_d;
         kx_q        <= kx_d;
         pix_q       <= pix_d;
         acc_q       <= acc_d;
         relu_q      <= relu_d;
         out_valid_q <= wr_en;
         if (wr_en) begin
            out_idx_q  <= pix_q;
            out_data_q <= post_val;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NPIX; i++) begin
            out_words_q[i] <= '0;
         end
      end else if (wr_en) begin
         out_words_q[pix_q] <= post_val;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_idx     = out_idx_q;
   assign out_data    = out_data_q;
   assign busy        = (state_q == S_MAC) || (state_q == S_WRITE);
   assign done        = (state_q == S_DONE);
   assign dbg_state_o = state_q;

endmodule
